// File: rtl/booth_pkg.sv
// ============================================================================
// booth_pkg : shared constants, Booth digit type and triplet encoder
// Optional macro BOOTH_MULT_UNSIGNED_EN selects unsigned operand mode.
// Revision : 1.0
// ============================================================================
`default_nettype none

package booth_pkg;

   localparam int WIDTH  = 16;
   localparam int PROD_W = 2 * WIDTH;

`ifdef BOOTH_MULT_UNSIGNED_EN
   localparam bit UNSIGNED_MODE = 1'b1;
`else
   localparam bit UNSIGNED_MODE = 1'b0;
`endif

   // Unsigned operands need one extra digit to absorb the zero-extended top bits.
   function automatic int num_pp(input int w);
      return UNSIGNED_MODE ? (w / 2 + 1) : (w / 2);
   endfunction

   localparam int NUM_PP = num_pp(WIDTH);

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      POS1 = 3'd1,
      POS2 = 3'd2,
      NEG1 = 3'd3,
      NEG2 = 3'd4
   } booth_digit_t;

   function automatic booth_digit_t encode(input logic [2:0] triplet);
      case (triplet)
         3'b001, 3'b010: return POS1;
         3'b011:         return POS2;
         3'b100:         return NEG2;
         3'b101, 3'b110: return NEG1;
         default:        return ZERO;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/booth_multiplier_if.sv
// ============================================================================
// booth_multiplier_if : operand/result bundle for the Booth multiplier
// Revision : 1.0
// ============================================================================
`default_nettype none

interface booth_multiplier_if #(
   parameter int WIDTH = booth_pkg::WIDTH
);
   logic                 in_valid;
   logic [WIDTH-1:0]     x;
   logic [WIDTH-1:0]     y;
   logic                 out_valid;
   logic [2*WIDTH-1:0]   result;

   modport master (output in_valid, x, y, input  out_valid, result);
   modport slave  (input  in_valid, x, y, output out_valid, result);
endinterface

`default_nettype wire

// File: rtl/booth_pp_gen.sv
// ============================================================================
// booth_pp_gen : one radix-4 Booth partial product from a y triplet and x
// Revision : 1.0
// ============================================================================
`default_nettype none

module booth_pp_gen
   import booth_pkg::*;
#(
   parameter int PP_W = WIDTH + 1
) (
   input  logic [2:0]      triplet,
   input  logic [PP_W-1:0] x_ext,
   output logic [PP_W-1:0] pp,
   output logic            neg
);

   booth_digit_t digit;

   // Negative digits emit the one's complement; the +1 travels on neg.
   always_comb begin
      digit = encode(triplet);
      pp    = '0;
      neg   = 1'b0;
      case (digit)
         POS1: pp = x_ext;
         POS2: pp = {x_ext[PP_W-2:0], 1'b0};
         NEG1: begin
            pp  = ~x_ext;
            neg = 1'b1;
         end
         NEG2: begin
            pp  = ~{x_ext[PP_W-2:0], 1'b0};
            neg = 1'b1;
         end
         default: pp = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/booth_multiplier.sv
// ============================================================================
// booth_multiplier : registered radix-4 Booth multiplier, 1-cycle latency
// Optional macro BOOTH_MULT_UNSIGNED_EN (via booth_pkg) selects unsigned mode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module booth_multiplier
   import booth_pkg::*;
#(
   parameter int WIDTH = booth_pkg::WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   booth_multiplier_if.slave  bus
);

   localparam int c_prod_w = 2 * WIDTH;
   localparam int c_num_pp = num_pp(WIDTH);
   localparam int c_pp_w   = UNSIGNED_MODE ? (WIDTH + 2) : (WIDTH + 1);

   logic [c_pp_w-1:0]     x_ext;
   logic [2*c_num_pp:0]   y_ext;
   logic [c_pp_w-1:0]     pp [c_num_pp];
   logic [c_num_pp-1:0]   neg;
   logic [c_prod_w-1:0]   product;

   logic [c_prod_w-1:0]   result_d, result_q;
   logic                  out_valid_d, out_valid_q;

   // y_ext carries the implicit y[-1]=0 at bit 0.
   if (UNSIGNED_MODE) begin : g_unsigned
      assign x_ext = {2'b00, bus.x};
      assign y_ext = {2'b00, bus.y, 1'b0};
   end else begin : g_signed
      assign x_ext = {bus.x[WIDTH-1], bus.x};
      assign y_ext = {bus.y, 1'b0};
   end

   for (genvar i = 0; i < c_num_pp; i++) begin : g_pp
      booth_pp_gen #(
         .PP_W    (c_pp_w)
      ) u_pp_gen (
         .triplet (y_ext[2*i+2 -: 3]),
         .x_ext   (x_ext),
         .pp      (pp[i]),
         .neg     (neg[i])
      );
   end

   // Carry-save accumulation; correction bits share one row as their columns never collide.
   always_comb begin : reduce
      logic [c_prod_w-1:0] row;
      logic [c_prod_w-1:0] sum_s;
      logic [c_prod_w-1:0] sum_c;
      logic [c_prod_w-1:0] nxt_s;
      sum_s = '0;
      for (int i = 0; i < c_num_pp; i++) begin
         sum_s[2*i] = neg[i];
      end
      sum_c = '0;
      for (int i = 0; i < c_num_pp; i++) begin
         row   = {{(c_prod_w-c_pp_w){pp[i][c_pp_w-1]}}, pp[i]} << (2*i);
         nxt_s = sum_s ^ sum_c ^ row;
         sum_c = ((sum_s & sum_c) | (sum_s & row) | (sum_c & row)) << 1;
         sum_s = nxt_s;
      end
      product = sum_s + sum_c;
   end

   always_comb begin
      result_d    = result_q;
      out_valid_d = 1'b0;
      if (bus.in_valid) begin
         result_d    = product;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.result    = result_q;
   assign bus.out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_multiplier.sv
// ============================================================================
// tb_booth_multiplier : scoreboard bench for booth_multiplier
// Honours BOOTH_MULT_UNSIGNED_EN for the reference model and corner table.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_booth_multiplier;

   localparam int W = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   booth_multiplier_if #(.WIDTH(W)) bus ();

   booth_multiplier #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic        v;
      logic [31:0] r;
   } exp_t;

   exp_t        sb [$];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] held  = '0;

   function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
`ifdef BOOTH_MULT_UNSIGNED_EN
      longint ua = longint'(a);
      longint ub = longint'(b);
      return 32'(ua * ub);
`else
      longint sa = longint'($signed(a));
      longint sb_ = longint'($signed(b));
      return 32'(sa * sb_);
`endif
   endfunction

   // Drive one cycle; the expected post-edge state goes to the scoreboard.
   task automatic step(input logic rn, input logic v, input logic [15:0] a,
                       input logic [15:0] b, input bit fixed, input logic [31:0] k);
      exp_t e;
      rst_n        = rn;
      bus.in_valid = v;
      bus.x        = a;
      bus.y        = b;
      @(posedge clk);
      if (!rn)    held = '0;
      else if (v) held = fixed ? k : ref_mul(a, b);
      e.v = rn & v;
      e.r = held;
      sb.push_back(e);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            tests++;
            if (bus.out_valid !== e.v) begin
               fails++;
               $display("FAIL out_valid: got %b want %b at %0t", bus.out_valid, e.v, $time);
            end
            tests++;
            if (bus.result !== e.r) begin
               fails++;
               $display("FAIL result: got %h want %h at %0t", bus.result, e.r, $time);
            end
         end
      end
   end

   logic [15:0] cx [7];
   logic [15:0] cy [7];
   logic [31:0] ck [7];

   initial begin : driver
      cx[0] = 16'hFFFF; cy[0] = 16'hFFFF;
      cx[1] = 16'h8000; cy[1] = 16'h8000; ck[1] = 32'h40000000;
      cx[2] = 16'h7FFF; cy[2] = 16'h8000;
      cx[3] = 16'h8000; cy[3] = 16'h0001;
      cx[4] = 16'hFFFF; cy[4] = 16'h0002;
      cx[5] = 16'h0000; cy[5] = 16'h8000; ck[5] = 32'h00000000;
      cx[6] = 16'h1234; cy[6] = 16'h0000; ck[6] = 32'h00000000;
`ifdef BOOTH_MULT_UNSIGNED_EN
      ck[0] = 32'hFFFE0001;
      ck[2] = 32'h3FFF8000;
      ck[3] = 32'h00008000;
      ck[4] = 32'h0001FFFE;
`else
      ck[0] = 32'h00000001;
      ck[2] = 32'hC0008000;
      ck[3] = 32'hFFFF8000;
      ck[4] = 32'hFFFFFFFE;
`endif

      // Reset wins over in_valid
      step(1'b0, 1'b1, 16'd5, 16'd7, 1'b0, '0);
      step(1'b0, 1'b1, 16'd5, 16'd7, 1'b0, '0);
      step(1'b1, 1'b1, 16'd5, 16'd7, 1'b1, 32'd35);

      for (int i = 0; i <= 32000; i += 1000)
         for (int j = 0; j <= 32000; j += 1000)
            step(1'b1, 1'b1, 16'(i), 16'(j), 1'b1, 32'(i * j));

      for (int i = 0; i < 7; i++)
         step(1'b1, 1'b1, cx[i], cy[i], 1'b1, ck[i]);

      // Hold with wandering operands
      step(1'b1, 1'b1, 16'd300, 16'hFFFD, 1'b0, '0);
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0, '0);

      // Mid-stream reset
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'b0, '0);
      step(1'b0, 1'b1, 16'd9, 16'd9, 1'b0, '0);
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'b0, '0);

      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
              16'($urandom), 16'($urandom), 1'b0, '0);

      for (int i = 0; i < 8 && sb.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d entries left, want 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
